// File: rtl/irq_ctrl.sv
// Interrupt request controller: synchronizes and latches peripheral interrupt lines
// per channel (level or rising-edge), gates them with an enable and drives the CPU irq inputs.
module irq_ctrl #(
    parameter int IRQ_CH  = 8,
    parameter int SYNC_ST = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IRQ_CH-1:0] src_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [1:0]        addr_i,
    input  logic [31:0]       wr_data_i,
    output logic [31:0]       rd_data_o,
    output logic              ack_o,
    output logic [IRQ_CH-1:0] irq_o,
    output logic              irq_any_o
);

    typedef enum logic [1:0] {
        REG_PENDING = 2'd0,
        REG_ENABLE  = 2'd1,
        REG_MODE    = 2'd2,
        REG_RAW     = 2'd3
    } reg_addr_e;

    logic [SYNC_ST-1:0][IRQ_CH-1:0] sync_q;
    logic [IRQ_CH-1:0] prev_q;
    logic [IRQ_CH-1:0] pending_q, pending_d;
    logic [IRQ_CH-1:0] enable_q,  enable_d;
    logic [IRQ_CH-1:0] mode_q,    mode_d;
    logic [IRQ_CH-1:0] irq_q,     irq_d;
    logic              irq_any_q, irq_any_d;
    logic              ack_q;
    logic [31:0]       rd_data_q, rd_data_d;

    logic [IRQ_CH-1:0] s;
    logic [IRQ_CH-1:0] clr;
    logic              wr_en;
    logic              rd_en;
    reg_addr_e         reg_sel;

    assign s       = sync_q[SYNC_ST-1];
    assign wr_en   = req_i & we_i;
    assign rd_en   = req_i & ~we_i;
    assign reg_sel = reg_addr_e'(addr_i);

    // Write-data bits above the channel count have no register behind them.
    generate
        if (IRQ_CH < 32) begin : g_unused_wr
            logic unused_wr_hi;
            assign unused_wr_hi = ^wr_data_i[31:IRQ_CH];
        end
    endgenerate

    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        clr       = '0;
        enable_d  = enable_q;
        mode_d    = mode_q;
        rd_data_d = '0;

        if (wr_en) begin
            case (reg_sel)
                REG_PENDING: clr      = wr_data_i[IRQ_CH-1:0];
                REG_ENABLE:  enable_d = wr_data_i[IRQ_CH-1:0];
                REG_MODE:    mode_d   = wr_data_i[IRQ_CH-1:0];
                default:     ;
            endcase
        end

        if (rd_en) begin
            case (reg_sel)
                REG_PENDING: rd_data_d[IRQ_CH-1:0] = pending_q;
                REG_ENABLE:  rd_data_d[IRQ_CH-1:0] = enable_q;
                REG_MODE:    rd_data_d[IRQ_CH-1:0] = mode_q;
                default:     rd_data_d[IRQ_CH-1:0] = s;
            endcase
        end

        // Edge channels: a fresh rising edge overrides a same-cycle clear.
        pending_d = (mode_q & ((s & ~prev_q) | (pending_q & ~clr))) | (~mode_q & s);

        irq_d     = pending_q & enable_q;
        irq_any_d = |(pending_q & enable_q);
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q    <= '0;
            prev_q    <= '0;
            pending_q <= '0;
            enable_q  <= '0;
            mode_q    <= '0;
            irq_q     <= '0;
            irq_any_q <= 1'b0;
            ack_q     <= 1'b0;
            rd_data_q <= '0;
        end else begin
            sync_q    <= {sync_q[SYNC_ST-2:0], src_i};
            prev_q    <= s;
            pending_q <= pending_d;
            enable_q  <= enable_d;
            mode_q    <= mode_d;
            irq_q     <= irq_d;
            irq_any_q <= irq_any_d;
            ack_q     <= req_i;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data_o = rd_data_q;
    assign ack_o     = ack_q;
    assign irq_o     = irq_q;
    assign irq_any_o = irq_any_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Testbench for irq_ctrl: directed scenarios followed by randomized traffic
// compared against a behavioural reference model.
module tb_irq_ctrl;

    localparam int IRQ_CH  = 8;
    localparam int SYNC_ST = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [IRQ_CH-1:0] src;
    logic              req;
    logic              we;
    logic [1:0]        addr;
    logic [31:0]       wr_data;
    logic [31:0]       rd_data;
    logic              ack;
    logic [IRQ_CH-1:0] irq;
    logic              irq_any;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    irq_ctrl #(.IRQ_CH(IRQ_CH), .SYNC_ST(SYNC_ST)) dut (
        .clk       (clk),
        .reset     (reset),
        .src_i     (src),
        .req_i     (req),
        .we_i      (we),
        .addr_i    (addr),
        .wr_data_i (wr_data),
        .rd_data_o (rd_data),
        .ack_o     (ack),
        .irq_o     (irq),
        .irq_any_o (irq_any)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // One bus access issued from a falling edge; returns on the falling edge where ack is high.
    task automatic bus(input logic w, input logic [1:0] a, input logic [31:0] d);
        req = 1'b1; we = w; addr = a; wr_data = d;
        @(negedge clk);
        req = 1'b0; we = 1'b0; addr = 2'd0; wr_data = '0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference model: src history queue (newest first) plus architectural registers.
    logic [IRQ_CH-1:0] hist[$];
    logic [IRQ_CH-1:0] m_pend, m_en, m_mode;
    logic [IRQ_CH-1:0] exp_irq;
    logic              exp_any, exp_ack;
    logic [31:0]       exp_rd;

    task automatic model_reset();
        hist.delete();
        for (int k = 0; k <= SYNC_ST; k++) hist.push_back('0);
        m_pend = '0; m_en = '0; m_mode = '0;
        exp_irq = '0; exp_any = 1'b0; exp_ack = 1'b0; exp_rd = '0;
    endtask

    // Advance the model across one rising edge using the inputs currently applied.
    task automatic model_step();
        logic [IRQ_CH-1:0] s_now, p_now, clr_now, nxt;
        s_now   = hist[SYNC_ST-1];
        p_now   = hist[SYNC_ST];
        clr_now = (req && we && addr == 2'd0) ? wr_data[IRQ_CH-1:0] : '0;

        exp_irq = m_pend & m_en;
        exp_any = (m_pend & m_en) != 0;
        exp_ack = req;
        exp_rd  = '0;
        if (req && !we) begin
            case (addr)
                2'd0:    exp_rd = 32'(m_pend);
                2'd1:    exp_rd = 32'(m_en);
                2'd2:    exp_rd = 32'(m_mode);
                default: exp_rd = 32'(s_now);
            endcase
        end

        for (int ch = 0; ch < IRQ_CH; ch++) begin
            if (m_mode[ch])
                nxt[ch] = (s_now[ch] && !p_now[ch]) || (m_pend[ch] && !clr_now[ch]);
            else
                nxt[ch] = s_now[ch];
        end
        m_pend = nxt;

        if (req && we && addr == 2'd1) m_en   = wr_data[IRQ_CH-1:0];
        if (req && we && addr == 2'd2) m_mode = wr_data[IRQ_CH-1:0];

        hist.push_front(src);
        void'(hist.pop_back());
    endtask

    initial begin
        reset = 1'b1; src = '0; req = 1'b0; we = 1'b0; addr = 2'd0; wr_data = '0;
        wait_cyc(2);
        check("irq_in_reset", 32'(irq), 32'h0);
        check("ack_in_reset", 32'(ack), 32'h0);
        reset = 1'b0;
        wait_cyc(1);

        // Every register reads zero after reset.
        for (int a = 0; a < 4; a++) begin
            bus(1'b0, 2'(a), '0);
            check($sformatf("rst_rd%0d", a), rd_data, 32'h0);
            check($sformatf("rst_ack%0d", a), 32'(ack), 32'h1);
        end
        check("rst_irq", 32'(irq), 32'h0);

        // Level channel 0: four edges from src rise to irq, same on fall.
        bus(1'b1, 2'd1, 32'h01);
        src[0] = 1'b1;
        wait_cyc(3);
        check("lvl_rise_early", 32'(irq), 32'h00);
        wait_cyc(1);
        check("lvl_rise_irq", 32'(irq), 32'h01);
        check("lvl_rise_any", 32'(irq_any), 32'h1);
        src[0] = 1'b0;
        wait_cyc(3);
        check("lvl_fall_early", 32'(irq), 32'h01);
        wait_cyc(1);
        check("lvl_fall_irq", 32'(irq), 32'h00);

        // Edge channel 2: a one-cycle pulse latches until cleared.
        bus(1'b1, 2'd2, 32'h04);
        bus(1'b1, 2'd1, 32'h04);
        src[2] = 1'b1;
        wait_cyc(1);
        src[2] = 1'b0;
        wait_cyc(6);
        bus(1'b0, 2'd0, '0);
        check("edge_pend", rd_data, 32'h04);
        check("edge_irq", 32'(irq), 32'h04);
        wait_cyc(3);
        check("edge_hold", 32'(irq), 32'h04);
        bus(1'b1, 2'd0, 32'h04);
        check("w1c_irq_same", 32'(irq), 32'h04);
        wait_cyc(1);
        check("w1c_irq_after", 32'(irq), 32'h00);
        bus(1'b0, 2'd0, '0);
        check("w1c_pend", rd_data, 32'h00);

        // Edge channel 3: clear lands on the same edge as a new rising edge.
        bus(1'b1, 2'd2, 32'h0C);
        src[3] = 1'b1;
        wait_cyc(2);
        bus(1'b1, 2'd0, 32'h08);
        bus(1'b0, 2'd0, '0);
        check("set_wins", rd_data, 32'h08);
        bus(1'b1, 2'd0, 32'h08);
        bus(1'b0, 2'd0, '0);
        check("clr_no_edge", rd_data, 32'h00);
        src[3] = 1'b0;

        // Disabled channel 7 still latches; enabling it raises irq.
        bus(1'b1, 2'd1, 32'h00);
        bus(1'b1, 2'd2, 32'h8C);
        src[7] = 1'b1;
        wait_cyc(5);
        check("dis_irq", 32'(irq), 32'h00);
        bus(1'b0, 2'd0, '0);
        check("dis_pend", rd_data, 32'h80);
        bus(1'b1, 2'd1, 32'h80);
        check("en_irq_same", 32'(irq), 32'h00);
        wait_cyc(1);
        check("en_irq", 32'(irq), 32'h80);
        check("en_any", 32'(irq_any), 32'h1);

        // Back-to-back write then read, then reset in the middle of an access.
        req = 1'b1; we = 1'b1; addr = 2'd1; wr_data = 32'hFF;
        @(negedge clk);
        check("b2b_ack1", 32'(ack), 32'h1);
        check("b2b_rd1", rd_data, 32'h0);
        we = 1'b0; wr_data = '0;
        @(negedge clk);
        check("b2b_ack2", 32'(ack), 32'h1);
        check("b2b_rd2", rd_data, 32'h000000FF);
        req = 1'b0;
        @(negedge clk);
        check("b2b_ack_off", 32'(ack), 32'h0);
        check("b2b_irq", 32'(irq), 32'h80);
        req = 1'b1; we = 1'b0; addr = 2'd1;
        @(negedge clk);
        check("mid_ack", 32'(ack), 32'h1);
        reset = 1'b1;
        #1;
        check("rst_ack_now", 32'(ack), 32'h0);
        check("rst_irq_now", 32'(irq), 32'h0);
        check("rst_any_now", 32'(irq_any), 32'h0);
        check("rst_rd_now", rd_data, 32'h0);
        req = 1'b0; addr = 2'd0; src = '0;
        model_reset();
        @(negedge clk);
        reset = 1'b0;

        // Randomized traffic against the reference model.
        for (int i = 0; i < 2000; i++) begin
            for (int ch = 0; ch < IRQ_CH; ch++)
                if ($urandom_range(7) == 0) src[ch] = ~src[ch];
            req     = ($urandom_range(2) == 0);
            we      = req && $urandom_range(1) == 1;
            addr    = req ? 2'($urandom_range(3)) : 2'd0;
            wr_data = (req && we) ? $urandom : '0;
            if (i == 1000) begin
                reset = 1'b1;
                #1;
                model_reset();
                check("rnd_rst_irq", 32'(irq), 32'h0);
                check("rnd_rst_ack", 32'(ack), 32'h0);
                @(negedge clk);
                reset = 1'b0;
            end else begin
                model_step();
                @(negedge clk);
                check("rnd_irq", 32'(irq), 32'(exp_irq));
                check("rnd_any", 32'(irq_any), 32'(exp_any));
                check("rnd_ack", 32'(ack), 32'(exp_ack));
                check("rnd_rd", rd_data, exp_rd);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
